// File: rtl/entrada_tempo.sv
// -----------------------------------------------------------------------------
// entrada_tempo
// Time-entry register for the microwave controller. Takes the keypad
// encoder's digit and valid flag, synchronises and debounces them, and shifts
// one digit per key press into a 4-digit MM:SS buffer.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a press or a
//                    release (1..255, default 4)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   BCD[3:0]     digit from the keypad encoder
//   valido       encoder valid flag, high while a key is held
//   habilita     entry enable; low suppresses digit commits
//   limpar       synchronous clear of the buffer (wins over a commit)
//   min_d/min_u  minutes tens/units
//   seg_d/seg_u  seconds tens/units
//   num_digitos  digits entered so far, 0..4
//   cheio        buffer full (num_digitos == 4)
//   digito_novo  one-cycle pulse on each accepted digit
//
// Build option
//   ENTRADA_SATURA_EN  when defined, the seconds outputs read 5/9 whenever the
//                      stored seconds-tens digit exceeds 5; storage unchanged.
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE         | no key; waiting for valido
// PRESS_WAIT   | key seen, counting stable cycles with the same digit
// HELD         | press accepted; waiting for the key to be released
// RELEASE_WAIT | key released, counting stable low cycles before re-arming
// -----------------------------------------------------------------------------
module entrada_tempo #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] BCD,
    input  logic       valido,
    input  logic       habilita,
    input  logic       limpar,
    output logic [3:0] min_d,
    output logic [3:0] min_u,
    output logic [3:0] seg_d,
    output logic [3:0] seg_u,
    output logic [2:0] num_digitos,
    output logic       cheio,
    output logic       digito_novo
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } estado_t;

    // Input synchronisers
    logic       v_s1, v_s;
    logic [3:0] bcd_s1, bcd_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1   <= 1'b0;
            v_s    <= 1'b0;
            bcd_s1 <= 4'd0;
            bcd_s  <= 4'd0;
        end else begin
            v_s1   <= valido;
            v_s    <= v_s1;
            bcd_s1 <= BCD;
            bcd_s  <= bcd_s1;
        end
    end

    // Debounce FSM
    estado_t         state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bcd_l_q, bcd_l_d;
    logic            aceita;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_l_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_l_q <= bcd_l_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_l_d = bcd_l_q;
        aceita  = 1'b0;
        case (state_q)
            IDLE: begin
                if (v_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                    bcd_l_d = bcd_s;
                end
            end
            PRESS_WAIT: begin
                // A digit change while held counts as a new press attempt,
                // so it restarts from IDLE rather than extending this one.
                if (!v_s || (bcd_s != bcd_l_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    aceita  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!v_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (v_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Digit buffer
    logic [3:0] st_md, st_mu, st_sd, st_su;
    logic [2:0] num_q;
    logic       cheio_q;
    logic       pulso_q;
    logic       commit;

    // A press that fails any gate is still consumed by the FSM above.
    assign commit = aceita && habilita && !limpar &&
                    (bcd_l_q <= 4'd9) && (num_q < 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_md   <= 4'd0;
            st_mu   <= 4'd0;
            st_sd   <= 4'd0;
            st_su   <= 4'd0;
            num_q   <= 3'd0;
            cheio_q <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            pulso_q <= 1'b0;
            if (limpar) begin
                st_md   <= 4'd0;
                st_mu   <= 4'd0;
                st_sd   <= 4'd0;
                st_su   <= 4'd0;
                num_q   <= 3'd0;
                cheio_q <= 1'b0;
            end else if (commit) begin
                st_md   <= st_mu;
                st_mu   <= st_sd;
                st_sd   <= st_su;
                st_su   <= bcd_l_q;
                num_q   <= num_q + 3'd1;
                cheio_q <= (num_q == 3'd3);
                pulso_q <= 1'b1;
            end
        end
    end

    assign min_d       = st_md;
    assign min_u       = st_mu;
    assign num_digitos = num_q;
    assign cheio       = cheio_q;
    assign digito_novo = pulso_q;

`ifdef ENTRADA_SATURA_EN
    logic sat;
    assign sat   = (st_sd > 4'd5);
    assign seg_d = sat ? 4'd5 : st_sd;
    assign seg_u = sat ? 4'd9 : st_su;
`else
    assign seg_d = st_sd;
    assign seg_u = st_su;
`endif

endmodule
